// File: rtl/nand_erase_issuer.sv
// Block-erase command issuer: accepts scheduler requests, strobes the erase command into the
// PHY sequencer, tracks PHY status to completion with a bounded wait, and returns a completion record.
module nand_erase_issuer #(
    parameter int unsigned          TIMEOUT_W   = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 24'hFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [15:0] i_req_id,
    input  logic [23:0] i_req_row,
    input  logic        i_req_dae,
    input  logic        i_req_enh,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic        o_isefirst,
    output logic [15:0] o_cmd,
    output logic [15:0] o_cmd_id,
    output logic [47:0] o_addr,
    output logic [63:0] o_data,
    output logic [31:0] o_cmd_param,
    output logic        o_keep_wait,
    input  logic [1:0]  i_phy_status,
    output logic        o_done_valid,
    input  logic        i_done_ready,
    output logic [15:0] o_done_id,
    output logic        o_done_timeout,
    output logic        o_done_err,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_RUN     = 3'd2,
        S_WAITRDY = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_MAX - TIMEOUT_W'(1);

    state_e               state_q;
    logic                 req_ready_q;
    logic [15:0]          id_q;
    logic [23:0]          row_q;
    logic                 dae_q;
    logic                 enh_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 done_valid_q;
    logic [15:0]          done_id_q;
    logic                 done_timeout_q;
    logic                 done_err_q;

    logic accept;
    logic timeout_hit;

    // Every channel transfers on a cycle where valid and ready are both high; a valid, once
    // raised, is held with stable payload until it transfers. The command strobe is the
    // exception: the PHY leaves IDLE on valid alone, so it is only raised while ready is high.
    assign accept      = i_req_valid & req_ready_q;
    assign timeout_hit = (cnt_q == TO_LAST);

    assign o_req_ready    = req_ready_q;
    assign o_cmd_valid    = (state_q == S_ISSUE) & i_cmd_ready;
    assign o_isefirst     = dae_q;
    assign o_cmd          = 16'hD060;
    assign o_cmd_id       = id_q;
    assign o_addr         = {24'h0, row_q};
    assign o_data         = '0;
    // Bit 15 marks a block erase, bit 14 selects the enhanced status wait.
    assign o_cmd_param    = {16'h0, 1'b1, enh_q, 10'h0, 3'd3, 1'b1};
    assign o_keep_wait    = 1'b0;
    assign o_done_valid   = done_valid_q;
    assign o_done_id      = done_id_q;
    assign o_done_timeout = done_timeout_q;
    assign o_done_err     = done_err_q;
    assign o_dbg_state    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            req_ready_q    <= 1'b0;
            id_q           <= '0;
            row_q          <= '0;
            dae_q          <= 1'b0;
            enh_q          <= 1'b0;
            cnt_q          <= '0;
            done_valid_q   <= 1'b0;
            done_id_q      <= '0;
            done_timeout_q <= 1'b0;
            done_err_q     <= 1'b0;
        end else begin
            req_ready_q <= (state_q == S_IDLE) && (i_phy_status == 2'b00) && !accept;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        id_q    <= i_req_id;
                        row_q   <= i_req_row;
                        dae_q   <= i_req_dae;
                        enh_q   <= i_req_enh;
                        cnt_q   <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_cmd_ready) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN, S_WAITRDY: begin
                    cnt_q <= cnt_q + TIMEOUT_W'(1);
                    // A one-cycle READY outranks both the error and the timeout exits.
                    if (i_phy_status == 2'b11) begin
                        state_q        <= S_DONE;
                        done_valid_q   <= 1'b1;
                        done_id_q      <= id_q;
                        done_timeout_q <= 1'b0;
                        done_err_q     <= 1'b0;
                    end else if ((state_q == S_WAITRDY) && (i_phy_status == 2'b00)) begin
                        state_q        <= S_DONE;
                        done_valid_q   <= 1'b1;
                        done_id_q      <= id_q;
                        done_timeout_q <= 1'b0;
                        done_err_q     <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q        <= S_DONE;
                        done_valid_q   <= 1'b1;
                        done_id_q      <= id_q;
                        done_timeout_q <= 1'b1;
                        done_err_q     <= 1'b0;
                    end else if ((state_q == S_RUN) && (i_phy_status != 2'b00)) begin
                        state_q <= S_WAITRDY;
                    end
                end
                S_DONE: begin
                    if (i_done_ready) begin
                        done_valid_q   <= 1'b0;
                        done_timeout_q <= 1'b0;
                        done_err_q     <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_erase_issuer.sv
// Bench for nand_erase_issuer: scripted PHY status model, directed vector table,
// randomized requests checked against a trace-level reference model, reset corner.
module tb_nand_erase_issuer;

  localparam int TMAX = 100;

  typedef struct {
    logic [15:0] id;
    logic [23:0] row;
    logic        dae;
    logic        enh;
    int          busy;
    int          wt;
    bit          rdy;
    int          nr_hold;
    int          done_hold;
    logic [31:0] exp_param;
    bit          exp_to;
    bit          exp_er;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_req_id;
  logic [23:0] i_req_row;
  logic        i_req_dae;
  logic        i_req_enh;
  logic        o_cmd_valid;
  logic        i_cmd_ready;
  logic        o_isefirst;
  logic [15:0] o_cmd;
  logic [15:0] o_cmd_id;
  logic [47:0] o_addr;
  logic [63:0] o_data;
  logic [31:0] o_cmd_param;
  logic        o_keep_wait;
  logic [1:0]  i_phy_status;
  logic        o_done_valid;
  logic        i_done_ready;
  logic [15:0] o_done_id;
  logic        o_done_timeout;
  logic        o_done_err;
  logic [2:0]  o_dbg_state;

  int tests = 0;
  int fails = 0;

  logic [17:0] exp_q[$];
  logic [1:0]  phy_q[$];
  vec_t        cur_v;
  logic        strobe_seen;
  logic        hold_nr;
  logic [1:0]  prev_status;
  vec_t        tbl[8];

  nand_erase_issuer #(.TIMEOUT_W(24), .TIMEOUT_MAX(24'd100)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_id(i_req_id), .i_req_row(i_req_row), .i_req_dae(i_req_dae), .i_req_enh(i_req_enh),
    .o_cmd_valid(o_cmd_valid), .i_cmd_ready(i_cmd_ready), .o_isefirst(o_isefirst),
    .o_cmd(o_cmd), .o_cmd_id(o_cmd_id), .o_addr(o_addr), .o_data(o_data),
    .o_cmd_param(o_cmd_param), .o_keep_wait(o_keep_wait), .i_phy_status(i_phy_status),
    .o_done_valid(o_done_valid), .i_done_ready(i_done_ready), .o_done_id(o_done_id),
    .o_done_timeout(o_done_timeout), .o_done_err(o_done_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] param_of(input logic enh);
    return enh ? 32'h0000_C007 : 32'h0000_8007;
  endfunction

  // PHY status k cycles after the strobe cycle: IDLE, BUSY*busy, WAIT*wt, optional READY, IDLE.
  function automatic logic [1:0] trace_at(input vec_t v, input int k);
    if (k == 0) return 2'b00;
    if (k <= v.busy) return 2'b01;
    if (k <= v.busy + v.wt) return 2'b10;
    if ((k == v.busy + v.wt + 1) && v.rdy) return 2'b11;
    return 2'b00;
  endfunction

  // The wait ends at the first READY, at the first IDLE after PHY activity, or when
  // TMAX wait cycles have elapsed; k_done is the index of the deciding cycle.
  function automatic void model(input vec_t v, output int k_done, output bit to, output bit er);
    bit seen;
    bit found;
    logic [1:0] st;
    seen = 0; found = 0; k_done = 0; to = 0; er = 0;
    for (int k = 0; k < TMAX; k++) begin
      st = trace_at(v, k);
      if (!found) begin
        if (st == 2'b11) begin
          k_done = k; found = 1;
        end else if (st == 2'b00 && seen) begin
          k_done = k; er = 1; found = 1;
        end else if (k == TMAX - 1) begin
          k_done = k; to = 1; found = 1;
        end else if (st != 2'b00) begin
          seen = 1;
        end
      end
    end
  endfunction

  // ---------------- PHY model ----------------
  always @(negedge clk) strobe_seen = o_cmd_valid & i_cmd_ready;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      phy_q.delete();
      i_phy_status = 2'b00;
      i_cmd_ready  = 1'b0;
    end else begin
      if (strobe_seen) begin
        for (int k = 0; k <= cur_v.busy + cur_v.wt + (cur_v.rdy ? 1 : 0); k++)
          phy_q.push_back(trace_at(cur_v, k));
        strobe_seen = 1'b0;
      end
      i_phy_status = (phy_q.size() > 0) ? phy_q.pop_front() : 2'b00;
      i_cmd_ready  = !hold_nr && (phy_q.size() == 0) && (i_phy_status == 2'b00);
    end
  end

  // Strobe only into an idle, ready PHY; request ready only after an idle status.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_cmd_valid) begin
        tests++;
        if (!i_cmd_ready || i_phy_status != 2'b00) begin
          fails++;
          $display("FAIL strobe_gate: got ready=%0b status=%0b expected ready=1 status=0", i_cmd_ready, i_phy_status);
        end
      end
      if (o_req_ready) begin
        tests++;
        if (prev_status != 2'b00) begin
          fails++;
          $display("FAIL req_ready_status: got prev status %0b expected 0", prev_status);
        end
      end
    end
    prev_status = i_phy_status;
  end

  // ---------------- drivers ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"}, {o_cmd_valid, o_req_ready, o_done_valid, o_done_timeout, o_done_err, o_isefirst}, 6'b0);
    check({tag, "_cmd"}, o_cmd, 16'hD060);
    check({tag, "_addr"}, o_addr, 48'h0);
    check({tag, "_cmd_id"}, o_cmd_id, 16'h0);
    check({tag, "_param"}, o_cmd_param, 32'h0000_8007);
    check({tag, "_done_id"}, o_done_id, 16'h0);
  endtask

  task automatic send_req(input vec_t v, output bit ok);
    int n;
    cur_v = v;
    hold_nr = (v.nr_hold > 0);
    i_req_valid = 1'b1;
    i_req_id = v.id; i_req_row = v.row; i_req_dae = v.dae; i_req_enh = v.enh;
    ok = 0; n = 0;
    while (!ok && n < 400) begin
      @(negedge clk);
      if (o_req_ready) ok = 1;
      @(posedge clk); #1;
      n++;
    end
    i_req_valid = 1'b0;
    check("accept_seen", ok, 1);
  endtask

  task automatic wait_strobe(output int n, output bit ok);
    ok = 0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (o_cmd_valid) ok = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("strobe_seen", ok, 1);
  endtask

  task automatic run_req(input vec_t v);
    int k_exp, n, lat;
    bit to_m, er_m, ok, stable_ok, pending;
    logic [17:0] exp;
    logic [1:0] st_d1;
    model(v, k_exp, to_m, er_m);
    exp_q.push_back({v.id, v.exp_to, v.exp_er});
    send_req(v, ok);
    if (!ok) begin void'(exp_q.pop_back()); return; end
    for (int i = 0; i < v.nr_hold; i++) begin
      @(negedge clk);
      check("gated_valid", o_cmd_valid, 0);
      if (i == v.nr_hold - 1) hold_nr = 1'b0;
      @(posedge clk); #1;
    end
    wait_strobe(n, ok);
    if (!ok) begin void'(exp_q.pop_back()); return; end
    check("strobe_latency", n, 0);
    check("strobe_cmd", o_cmd, 16'hD060);
    check("strobe_addr", o_addr, {24'h0, v.row});
    check("strobe_id", o_cmd_id, v.id);
    check("strobe_isefirst", o_isefirst, v.dae);
    check("strobe_param", o_cmd_param, v.exp_param);
    check("strobe_consts", {o_data, o_keep_wait}, 65'h0);
    stable_ok = 1; ok = 0; lat = 0;
    while (!ok && lat < 400) begin
      @(posedge clk); #1;
      @(negedge clk);
      lat++;
      if (lat == 1) check("strobe_one_cycle", o_cmd_valid, 0);
      if (o_cmd_id !== v.id || o_isefirst !== v.dae || o_addr !== {24'h0, v.row} ||
          o_cmd_param !== v.exp_param || o_cmd !== 16'hD060) stable_ok = 0;
      if (o_done_valid) ok = 1;
    end
    check("done_seen", ok, 1);
    exp = exp_q.pop_front();
    if (!ok) return;
    check("done_latency", lat, k_exp + 2);
    check("model_flags", {to_m, er_m}, {v.exp_to, v.exp_er});
    check("done_record", {o_done_id, o_done_timeout, o_done_err}, exp);
    for (int i = 0; i < v.done_hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_cmd_id !== v.id || o_isefirst !== v.dae || o_addr !== {24'h0, v.row}) stable_ok = 0;
      check("done_held", {o_done_valid, o_done_id, o_done_timeout, o_done_err}, {1'b1, exp});
    end
    check("fields_stable", stable_ok, 1);
    @(posedge clk); #1;
    i_done_ready = 1'b1;
    @(negedge clk);
    pending = o_done_valid;
    @(posedge clk); #1;
    i_done_ready = 1'b0;
    @(negedge clk);
    check("handshake_valid", pending, 1);
    check("done_cleared", o_done_valid, 0);
    check("req_ready_d1", o_req_ready, 0);
    st_d1 = i_phy_status;
    @(posedge clk); #1;
    @(negedge clk);
    check("req_ready_d2", o_req_ready, (st_d1 == 2'b00));
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    bit ok, seen_done;
    int n, k_m;
    bit to_m, er_m;

    rst_n = 1'b0; i_req_valid = 1'b0; i_req_id = '0; i_req_row = '0;
    i_req_dae = 1'b0; i_req_enh = 1'b0; i_done_ready = 1'b0;
    i_cmd_ready = 1'b0; i_phy_status = 2'b00; hold_nr = 1'b0;
    strobe_seen = 1'b0; prev_status = 2'b00;
    cur_v = '{16'h0, 24'h0, 1'b0, 1'b0, 1, 0, 1'b1, 0, 0, 32'h0000_8007, 1'b0, 1'b0};

    // id, row, dae, enh, busy, wait, ready, cmd_ready hold, done hold, param, timeout, err
    tbl[0] = '{16'h0001, 24'h012345, 1'b0, 1'b0, 10, 50, 1'b1, 0, 0, 32'h0000_8007, 1'b0, 1'b0};
    tbl[1] = '{16'hA5A5, 24'hFEDCBA, 1'b1, 1'b1, 4, 20, 1'b1, 0, 0, 32'h0000_C007, 1'b0, 1'b0};
    tbl[2] = '{16'h0203, 24'h000010, 1'b0, 1'b1, 3, 5, 1'b1, 5, 0, 32'h0000_C007, 1'b0, 1'b0};
    tbl[3] = '{16'h0304, 24'h0ABCDE, 1'b1, 1'b0, 10, 150, 1'b0, 0, 2, 32'h0000_8007, 1'b1, 1'b0};
    tbl[4] = '{16'h0405, 24'h111111, 1'b0, 1'b0, 6, 0, 1'b0, 0, 0, 32'h0000_8007, 1'b0, 1'b1};
    tbl[5] = '{16'h0506, 24'h222222, 1'b1, 1'b1, 2, 3, 1'b1, 0, 8, 32'h0000_C007, 1'b0, 1'b0};
    tbl[6] = '{16'h0607, 24'h333333, 1'b0, 1'b0, 10, 87, 1'b1, 0, 1, 32'h0000_8007, 1'b0, 1'b0};
    tbl[7] = '{16'h0708, 24'h444444, 1'b0, 1'b1, 10, 89, 1'b1, 0, 1, 32'h0000_C007, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_req(tbl[i]);

    for (int i = 0; i < 16; i++) begin
      v.id        = 16'($urandom);
      v.row       = 24'($urandom);
      v.dae       = 1'($urandom_range(0, 1));
      v.enh       = 1'($urandom_range(0, 1));
      v.busy      = $urandom_range(1, 15);
      v.wt        = $urandom_range(0, 100);
      v.rdy       = ($urandom_range(0, 3) != 0);
      v.nr_hold   = $urandom_range(0, 3);
      v.done_hold = $urandom_range(0, 3);
      v.exp_param = param_of(v.enh);
      model(v, k_m, to_m, er_m);
      v.exp_to = to_m;
      v.exp_er = er_m;
      run_req(v);
    end

    // Reset while the PHY sits in WAIT: outputs drop at once, the request is abandoned.
    v = '{16'hBEEF, 24'h555555, 1'b1, 1'b1, 5, 200, 1'b0, 0, 0, 32'h0000_C007, 1'b0, 1'b0};
    send_req(v, ok);
    wait_strobe(n, ok);
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    phy_q.delete();
    i_phy_status = 2'b00;
    i_cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_done_valid) seen_done = 1;
    end
    check("no_done_after_reset", seen_done, 0);
    check("ready_after_reset", o_req_ready, 1);
    @(posedge clk); #1;
    run_req(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
